// File: rtl/sum_gather_pkg.sv
// Shared types, default sizes and helpers for the N-core partial-sum aggregator.
package sum_gather_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    COLLECT = 2'd1,
    ADD     = 2'd2,
    OUT     = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int NCORE_DEF  = 4;
  localparam int SUM_BW_DEF = 18;
  localparam int OUT_BW_DEF = SUM_BW_DEF + clog2(NCORE_DEF) + 1;
  localparam int IDX_BW     = (clog2(NCORE_DEF) < 1) ? 1 : clog2(NCORE_DEF);

  // Extends the low `width` bits of value to 64 bits; callers truncate to OUT_BW.
  function automatic logic [63:0] ext_sum(input logic [63:0] value, input int width,
                                          input logic signed_flag);
    logic [63:0] keep;
    logic        fill;
    keep = ~(64'hFFFF_FFFF_FFFF_FFFF << width);
    fill = signed_flag & value[6'(width - 1)];
    return (value & keep) | (fill ? ~keep : 64'd0);
  endfunction

endpackage

// File: rtl/sum_gather_slot.sv
// One core's capture slot: holds the sum, a captured flag and a one-cycle ack pulse.
module sum_gather_slot
  import sum_gather_pkg::*;
#(
  parameter int SUM_BW = SUM_BW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              req,
  input  logic [SUM_BW-1:0] data,
  output logic              captured,
  output logic              ack,
  output logic [SUM_BW-1:0] held
);

  logic              captured_q, captured_d;
  logic              ack_q, ack_d;
  logic [SUM_BW-1:0] data_q, data_d;
  logic              capture;

  assign capture = enable & req & ~captured_q;

  always_comb begin
    captured_d = captured_q;
    ack_d      = capture;
    data_d     = data_q;
    if (clear) begin
      captured_d = 1'b0;
    end else if (capture) begin
      captured_d = 1'b1;
      data_d     = data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      captured_q <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      captured_q <= captured_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
    end
  end

  assign captured = captured_q;
  assign ack      = ack_q;
  assign held     = data_q;

endmodule

// File: rtl/sum_gather.sv
// N-core partial-sum aggregator: collect per-core sums, add them serially,
// then hand the width-extended total downstream under valid/ready.
module sum_gather
  import sum_gather_pkg::*;
#(
  parameter int NCORE  = NCORE_DEF,
  parameter int SUM_BW = SUM_BW_DEF,
  parameter int OUT_BW = SUM_BW + $clog2(NCORE) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCORE-1:0]        core_mask,
  input  logic                    is_signed,
  input  logic [NCORE-1:0]        req_in,
  input  logic [NCORE*SUM_BW-1:0] sum_in,
  output logic [NCORE-1:0]        ack_out,
  output logic [OUT_BW-1:0]       sum_out,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [7:0]              round_cnt
);

  localparam int IDX_W = (clog2(NCORE) < 1) ? 1 : clog2(NCORE);

  state_e             state_q, state_d;
  logic [NCORE-1:0]   mask_q, mask_d;
  logic               sgn_q, sgn_d;
  logic [OUT_BW-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_BW-1:0]  sum_out_q, sum_out_d;
  logic               sum_valid_q, sum_valid_d;
  logic [7:0]         round_cnt_q, round_cnt_d;

  logic [NCORE-1:0]   captured;
  logic [NCORE-1:0]   collect_en;
  logic               slot_clear;
  logic               all_done;
  logic [SUM_BW-1:0]  slot_data [NCORE];
  logic [OUT_BW-1:0]  add_term;

  assign slot_clear = (state_q == START);
  assign collect_en = {NCORE{state_q == COLLECT}} & mask_q;
  assign all_done   = &(captured | ~mask_q);
  assign add_term   = OUT_BW'(ext_sum(64'(slot_data[idx_q]), SUM_BW, sgn_q));

  for (genvar g = 0; g < NCORE; g++) begin : g_slot
    sum_gather_slot #(.SUM_BW(SUM_BW)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .clear    (slot_clear),
      .enable   (collect_en[g]),
      .req      (req_in[g]),
      .data     (sum_in[g*SUM_BW +: SUM_BW]),
      .captured (captured[g]),
      .ack      (ack_out[g]),
      .held     (slot_data[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    sgn_d       = sgn_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    sum_out_d   = sum_out_q;
    sum_valid_d = sum_valid_q;
    round_cnt_d = round_cnt_q;
    case (state_q)
      START: begin
        mask_d  = core_mask;
        sgn_d   = is_signed;
        acc_d   = '0;
        idx_d   = '0;
        state_d = COLLECT;
      end
      COLLECT: begin
        if (all_done) state_d = ADD;
      end
      ADD: begin
        if (mask_q[idx_q]) acc_d = acc_q + add_term;
        // The final addition lands directly in the output register.
        if (idx_q == IDX_W'(NCORE - 1)) begin
          state_d     = OUT;
          sum_out_d   = acc_d;
          sum_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUT: begin
        if (sum_valid_q && sum_ready) begin
          sum_valid_d = 1'b0;
          round_cnt_d = round_cnt_q + 8'd1;
          state_d     = START;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= START;
      mask_q      <= '0;
      sgn_q       <= 1'b0;
      acc_q       <= '0;
      idx_q       <= '0;
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
      round_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      sgn_q       <= sgn_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      sum_out_q   <= sum_out_d;
      sum_valid_q <= sum_valid_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  assign sum_out   = sum_out_q;
  assign sum_valid = sum_valid_q;
  assign round_cnt = round_cnt_q;

endmodule

// File: tb/tb_sum_gather.sv
// Directed bench for sum_gather: expected totals go into a scoreboard queue when a
// round is launched and are popped when the DUT raises sum_valid.
module tb_sum_gather;

  localparam int NCORE  = 4;
  localparam int SUM_BW = 18;
  localparam int OUT_BW = 21;

  logic                    clk;
  logic                    reset;
  logic [NCORE-1:0]        core_mask;
  logic                    is_signed;
  logic [NCORE-1:0]        req_in;
  logic [NCORE*SUM_BW-1:0] sum_in;
  logic [NCORE-1:0]        ack_out;
  logic [OUT_BW-1:0]       sum_out;
  logic                    sum_valid;
  logic                    sum_ready;
  logic [7:0]              round_cnt;

  int checks = 0;
  int errors = 0;
  int exp_rounds = 0;
  logic [OUT_BW-1:0] sb [$];

  sum_gather #(.NCORE(NCORE), .SUM_BW(SUM_BW), .OUT_BW(OUT_BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .core_mask (core_mask),
    .is_signed (is_signed),
    .req_in    (req_in),
    .sum_in    (sum_in),
    .ack_out   (ack_out),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .round_cnt (round_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something below loops forever.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] global timeout");
  end

  // Advance one edge and settle past it before looking at outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference total: each enabled core's sum widened as signed or unsigned.
  function automatic logic [OUT_BW-1:0] expSum(input logic [3:0] mask, input logic sgn,
                                               input logic [3:0][SUM_BW-1:0] s);
    longint acc;
    acc = 0;
    for (int i = 0; i < NCORE; i++) begin
      if (mask[i]) acc += sgn ? longint'($signed(s[i])) : longint'(s[i]);
    end
    return OUT_BW'(acc);
  endfunction

  function automatic logic [3:0][SUM_BW-1:0] pack4(input logic [SUM_BW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // Drive a round's inputs and queue the total that round must produce.
  task automatic applyStimulus(input logic [3:0] mask, input logic sgn,
                               input logic [3:0][SUM_BW-1:0] s, input logic [3:0] req);
    core_mask = mask;
    is_signed = sgn;
    sum_in    = s;
    req_in    = req;
    sb.push_back(expSum(mask, sgn, s));
  endtask

  task automatic waitValid(output int cycles, output logic [3:0] ack_seen);
    cycles   = 0;
    ack_seen = '0;
    while (!sum_valid && cycles < 50) begin
      tick();
      cycles++;
      ack_seen |= ack_out;
    end
    checkOutput("valid_timeout", 64'(sum_valid), 64'd1);
  endtask

  task automatic checkTotal(input string tag);
    logic [OUT_BW-1:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    checkOutput(tag, 64'(sum_out), 64'(exp));
  endtask

  task automatic acceptTotal();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    exp_rounds++;
    checkOutput("valid_drop", 64'(sum_valid), 64'd0);
    checkOutput("round_cnt", 64'(round_cnt), 64'(exp_rounds[7:0]));
  endtask

  initial begin
    int         cyc;
    logic [3:0] seen;
    logic       stable;
    logic [OUT_BW-1:0] held;

    reset = 1'b0; core_mask = '0; is_signed = 1'b0; req_in = '0; sum_in = '0; sum_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_ack", 64'(ack_out), 64'd0);
    checkOutput("rst_sum", 64'(sum_out), 64'd0);
    checkOutput("rst_valid", 64'(sum_valid), 64'd0);
    checkOutput("rst_round", 64'(round_cnt), 64'd0);

    // Unsigned, all cores requesting together.
    applyStimulus(4'hF, 1'b0, pack4(18'd100, 18'd200, 18'd300, 18'd400), 4'hF);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("t1_ack_all", 64'(ack_out), 64'hF);
    req_in = '0;
    waitValid(cyc, seen);
    checkOutput("t1_latency", 64'(cyc), 64'd5);
    checkOutput("t1_no_reack", 64'(seen), 64'd0);
    checkTotal("t1_sum");
    acceptTotal();
    checkOutput("t1_sum_kept", 64'(sum_out), 64'd1000);

    // Signed, staggered requests three cycles apart, every core at -1.
    applyStimulus(4'hF, 1'b1, pack4(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF), 4'h0);
    tick();
    for (int i = 0; i < NCORE; i++) begin
      req_in[i] = 1'b1;
      tick();
      checkOutput($sformatf("t2_ack%0d", i), 64'(ack_out), 64'(4'b0001 << i));
      req_in[i] = 1'b0;
      if (i < NCORE - 1) begin
        tick();
        tick();
      end
    end
    waitValid(cyc, seen);
    checkOutput("t2_latency", 64'(cyc), 64'd5);
    checkTotal("t2_sum");
    acceptTotal();

    // Unsigned maximum values must not wrap.
    applyStimulus(4'hF, 1'b0, pack4(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF), 4'hF);
    tick();
    tick();
    req_in = '0;
    waitValid(cyc, seen);
    checkTotal("t3_sum");
    acceptTotal();

    // Masked cores 1 and 3 keep requesting and must never be acked.
    applyStimulus(4'b0101, 1'b0, pack4(18'd10, 18'd99, 18'd20, 18'd77), 4'hF);
    tick();
    tick();
    checkOutput("t4_ack", 64'(ack_out), 64'b0101);
    req_in = 4'b1010;
    waitValid(cyc, seen);
    checkOutput("t4_masked_ack", 64'(seen), 64'd0);
    checkTotal("t4_sum");
    acceptTotal();

    // Empty mask: total of zero after six cycles.
    applyStimulus(4'h0, 1'b0, pack4(18'd5, 18'd6, 18'd7, 18'd8), 4'h0);
    waitValid(cyc, seen);
    checkOutput("t5_latency", 64'(cyc), 64'd6);
    checkTotal("t5_sum");
    acceptTotal();

    // Backpressure while core 0 re-requests during OUT.
    applyStimulus(4'hF, 1'b0, pack4(18'd1, 18'd2, 18'd3, 18'd4), 4'hF);
    tick();
    tick();
    req_in = '0;
    waitValid(cyc, seen);
    checkTotal("t6_sum");
    held = sum_out;
    applyStimulus(4'b0001, 1'b0, pack4(18'd555, 18'd0, 18'd0, 18'd0), 4'b0001);
    stable = 1'b1;
    seen   = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      stable &= (sum_out === held) && (sum_valid === 1'b1);
      seen   |= ack_out;
    end
    checkOutput("t6_stable", 64'(stable), 64'd1);
    checkOutput("t6_no_ack_out", 64'(seen), 64'd0);
    acceptTotal();
    tick();
    checkOutput("t6_ack_early", 64'(ack_out), 64'd0);
    tick();
    checkOutput("t6_ack_collect", 64'(ack_out), 64'b0001);
    req_in = '0;
    waitValid(cyc, seen);
    checkTotal("t6b_sum");
    acceptTotal();

    // Reset asserted for one edge while the adder is on core index 2.
    applyStimulus(4'hF, 1'b0, pack4(18'd11, 18'd22, 18'd33, 18'd44), 4'hF);
    tick();
    tick();
    req_in = '0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    sb.delete();
    exp_rounds = 0;
    checkOutput("t7_rst_ack", 64'(ack_out), 64'd0);
    checkOutput("t7_rst_sum", 64'(sum_out), 64'd0);
    checkOutput("t7_rst_valid", 64'(sum_valid), 64'd0);
    checkOutput("t7_rst_round", 64'(round_cnt), 64'd0);
    applyStimulus(4'hF, 1'b1, pack4(18'h3FFF6, 18'd5, 18'd100, 18'h3FFFD), 4'hF);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("t7_ack_all", 64'(ack_out), 64'hF);
    req_in = '0;
    waitValid(cyc, seen);
    checkOutput("t7_latency", 64'(cyc), 64'd5);
    checkTotal("t7_sum");
    acceptTotal();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
